// File: rtl/mem_bus_if_pkg.sv
// Shared types for the memory-stage bus interface: access size, response
// error codes, controller states and small lane helpers.
package mem_bus_if_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_SIZE     = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Natural alignment: words on 4-byte, halves on 2-byte boundaries.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_WORD: return addr_lo != 2'b00;
      SZ_HALF: return addr_lo[0];
      default: return 1'b0;
    endcase
  endfunction

  // Store data is right-justified; unused upper lanes are driven as zero.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_HALF: return {16'h0000, wdata[15:0]};
      SZ_BYTE: return {24'h000000, wdata[7:0]};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_if_if.sv
// Core-side request/response handshake between the memory stage and the
// bus controller.
interface mem_bus_if_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, flush,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, flush,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_bus_if_load_ext.sv
// Load data extraction: picks the byte/half lane and sign- or zero-extends.
module load_ext
  import mem_bus_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Extend the low lane according to access size and signedness.
  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{is_signed & raw[7]}}, raw[7:0]};
      SZ_HALF: ext = {{16{is_signed & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_bus_if.sv
// Memory-stage bus controller: accepts one core access at a time, checks
// alignment/size, runs an acknowledged bus cycle with timeout, and returns a
// single-cycle response that a flush can suppress.
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_bus_if_if.slave  core,
  output logic [31:0]  DAD,
  inout  wire  [31:0]  DDT,
  output logic         MREQ,
  output logic         WRITE,
  output logic [1:0]   SIZE,
  input  logic         ACKD_n
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  err_q, err_d;
  logic        write_q, write_d;
  logic        signed_q, signed_d;
  logic        flush_q, flush_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] load_data;

  load_ext u_load_ext (
    .size      (size_q),
    .is_signed (signed_q),
    .raw       (DDT),
    .ext       (load_data)
  );

  // Next-state logic for request acceptance, bus wait/timeout and response.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    err_d    = err_q;
    write_d  = write_q;
    signed_d = signed_q;
    flush_d  = flush_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          flush_d = 1'b0;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = ERR_OK;
          if (core.req_size == SZ_RSVD) begin
            err_d   = ERR_SIZE;
            state_d = ST_DONE;
          end else if (misaligned(core.req_size, core.req_addr[1:0])) begin
            err_d   = ERR_MISALIGN;
            state_d = ST_DONE;
          end else begin
            addr_d   = core.req_addr;
            size_d   = core.req_size;
            write_d  = core.req_write;
            signed_d = core.req_signed;
            wdata_d  = store_lanes(core.req_size, core.req_wdata);
            state_d  = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // A flush never aborts the bus cycle; it only marks the response dead.
        flush_d = flush_q | core.flush;
        if (!ACKD_n) begin
          rdata_d = write_q ? '0 : load_data;
          err_d   = ERR_OK;
          state_d = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        flush_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      err_q    <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      flush_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      err_q    <= err_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      flush_q  <= flush_d;
      cnt_q    <= cnt_d;
    end
  end

  // Bus pins are qualified by MREQ so they fall to idle values outside BUS.
  assign MREQ  = (state_q == ST_BUS);
  assign WRITE = MREQ & write_q;
  assign SIZE  = MREQ ? size_q : 2'b00;
  assign DAD   = MREQ ? addr_q : '0;
  assign DDT   = WRITE ? wdata_q : 'z;

  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = (state_q == ST_DONE) & ~flush_q & ~core.flush;
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: directed accesses against a simple acknowledging
// memory, with a response scoreboard fed at request time.
module tb_mem_bus_if;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_if_if bus_if ();

  wire  [31:0] DDT;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;
  logic        tb_drv;
  logic [31:0] tb_ddt;

  assign DDT = tb_drv ? tb_ddt : 'z;

  mem_bus_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .core   (bus_if),
    .DAD    (DAD),
    .DDT    (DDT),
    .MREQ   (MREQ),
    .WRITE  (WRITE),
    .SIZE   (SIZE),
    .ACKD_n (ACKD_n)
  );

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned n_resp = 0;
  int unsigned n_exp_resp = 0;
  logic        prev_rv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b1 && bus_if.resp_valid === 1'b1) begin
      check("resp_single_pulse", 32'(prev_rv), 32'd0);
      check("resp_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("resp_rdata", bus_if.resp_rdata, e.rdata);
        check("resp_err", 32'(bus_if.resp_err), 32'(e.err));
      end
      n_resp++;
    end
    prev_rv = (rst === 1'b1) ? bus_if.resp_valid : 1'b0;
  end

  // fmode: 0 none, 1 flush with accept in IDLE, 2 flush during BUS, 3 flush in DONE.
  task automatic do_access(input string nm, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_dly, input logic [31:0] mem,
                           input logic [1:0] exp_err, input logic [31:0] exp_rd,
                           input logic [31:0] exp_ddt, input int fmode);
    logic exp_bus;
    logic exp_rv;
    int   cyc;
    int   exp_cyc;
    bit   done;
    exp_bus = (exp_err == 2'b00) || (exp_err == 2'b10);
    exp_rv  = (fmode <= 1);
    exp_cyc = (ack_dly < int'(TO)) ? ack_dly + 1 : int'(TO);
    cyc     = 0;
    done    = 1'b0;

    tick();
    bus_if.req_valid  = 1'b1;
    bus_if.req_write  = wr;
    bus_if.req_size   = sz;
    bus_if.req_signed = sg;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wd;
    bus_if.flush      = (fmode == 1);
    if (exp_rv) begin
      sb_q.push_back({exp_err, exp_rd});
      n_exp_resp++;
    end
    @(negedge clk);
    check({nm, "_ready"}, 32'(bus_if.req_ready), 32'd1);
    tick();
    bus_if.req_valid = 1'b0;
    bus_if.flush     = 1'b0;

    if (exp_bus) begin
      for (int i = 0; i < 40 && !done; i++) begin
        ACKD_n       = (i == ack_dly) ? 1'b0 : 1'b1;
        tb_drv       = !wr && (i == ack_dly);
        tb_ddt       = mem;
        bus_if.flush = (fmode == 2) && (i == 0);
        @(negedge clk);
        check({nm, "_mreq"}, 32'(MREQ), 32'd1);
        check({nm, "_dad"}, DAD, addr);
        check({nm, "_size"}, 32'(SIZE), 32'(sz));
        check({nm, "_write"}, 32'(WRITE), 32'(wr));
        if (wr) check({nm, "_ddt"}, DDT, exp_ddt);
        cyc++;
        tick();
        ACKD_n       = 1'b1;
        tb_drv       = 1'b0;
        bus_if.flush = 1'b0;
        if (MREQ == 1'b0) done = 1'b1;
      end
      check({nm, "_bus_cycles"}, 32'(cyc), 32'(exp_cyc));
      if (fmode == 3) bus_if.flush = 1'b1;
    end
    // DONE cycle
    @(negedge clk);
    check({nm, "_done_mreq"}, 32'(MREQ), 32'd0);
    check({nm, "_done_rv"}, 32'(bus_if.resp_valid), 32'(exp_rv));
    tick();
    bus_if.flush = 1'b0;
    // Back in IDLE
    @(negedge clk);
    check({nm, "_idle_rv"}, 32'(bus_if.resp_valid), 32'd0);
    check({nm, "_idle_ready"}, 32'(bus_if.req_ready), 32'd1);
    check({nm, "_idle_mreq"}, 32'(MREQ), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst               = 1'b0;
    ACKD_n            = 1'b1;
    tb_drv            = 1'b0;
    tb_ddt            = '0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_size   = 2'b00;
    bus_if.req_signed = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.req_wdata  = '0;
    bus_if.flush      = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_mreq", 32'(MREQ), 32'd0);
    check("rst_write", 32'(WRITE), 32'd0);
    check("rst_size", 32'(SIZE), 32'd0);
    check("rst_dad", DAD, 32'd0);
    check("rst_rv", 32'(bus_if.resp_valid), 32'd0);
    check("rst_rdata", bus_if.resp_rdata, 32'd0);
    check("rst_err", 32'(bus_if.resp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", 32'(bus_if.req_ready), 32'd1);

    //        name       wr  size   sg   addr          wdata         ack mem           err    rdata         ddt           fm
    do_access("wld",     0, 2'b00, 0, 32'h0800_0000, 32'h0,        1,  32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 32'h0,        0);
    do_access("sbld",    0, 2'b10, 1, 32'h0800_0003, 32'h0,        0,  32'h0000_0080, 2'b00, 32'hFFFF_FF80, 32'h0,        0);
    do_access("ubld",    0, 2'b10, 0, 32'h0800_0003, 32'h0,        0,  32'h0000_0080, 2'b00, 32'h0000_0080, 32'h0,        0);
    do_access("shld",    0, 2'b01, 1, 32'h0800_0002, 32'h0,        2,  32'h7777_8001, 2'b00, 32'hFFFF_8001, 32'h0,        0);
    do_access("uhld",    0, 2'b01, 0, 32'h0800_0002, 32'h0,        0,  32'h1234_F00D, 2'b00, 32'h0000_F00D, 32'h0,        0);
    do_access("hst_mis", 1, 2'b01, 0, 32'h0800_0001, 32'hABCD_1234, 0, 32'h0,         2'b01, 32'h0,         32'h0,        0);
    do_access("hst",     1, 2'b01, 0, 32'h0800_0002, 32'hABCD_1234, 1, 32'h0,         2'b00, 32'h0,         32'h0000_1234, 0);
    do_access("bst",     1, 2'b10, 0, 32'h0800_0003, 32'hAABB_CCDD, 0, 32'h0,         2'b00, 32'h0,         32'h0000_00DD, 0);
    do_access("wld2",    0, 2'b00, 0, 32'h0800_0008, 32'h0,        0,  32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 32'h0,        0);
    do_access("wst",     1, 2'b00, 0, 32'h0800_0004, 32'hCAFE_F00D, 3, 32'h0,         2'b00, 32'h0,         32'hCAFE_F00D, 0);
    do_access("wmis",    0, 2'b00, 0, 32'h0800_0002, 32'h0,        0,  32'h0,         2'b01, 32'h0,         32'h0,        0);
    do_access("rsvd",    0, 2'b11, 0, 32'h0800_0000, 32'h0,        0,  32'h0,         2'b11, 32'h0,         32'h0,        0);
    do_access("wld3",    0, 2'b00, 0, 32'h0800_000C, 32'h0,        0,  32'h1111_2222, 2'b00, 32'h1111_2222, 32'h0,        0);
    do_access("tmo",     0, 2'b00, 0, 32'h0800_0010, 32'h0,        99, 32'h0,         2'b10, 32'h0,         32'h0,        0);
    do_access("fl_bus",  0, 2'b00, 0, 32'h0800_0014, 32'h0,        2,  32'h3333_4444, 2'b00, 32'h3333_4444, 32'h0,        2);
    do_access("after_fl",0, 2'b00, 0, 32'h0800_0018, 32'h0,        0,  32'h5555_6666, 2'b00, 32'h5555_6666, 32'h0,        0);
    do_access("fl_idle", 0, 2'b10, 1, 32'h0800_0001, 32'h0,        1,  32'h0000_007F, 2'b00, 32'h0000_007F, 32'h0,        1);
    do_access("fl_done", 0, 2'b00, 0, 32'h0800_001C, 32'h0,        0,  32'h7777_8888, 2'b00, 32'h7777_8888, 32'h0,        3);

    // Acknowledge while no bus request is outstanding must be ignored.
    tick();
    ACKD_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_ack_mreq", 32'(MREQ), 32'd0);
      check("stray_ack_rv", 32'(bus_if.resp_valid), 32'd0);
      check("stray_ack_ready", 32'(bus_if.req_ready), 32'd1);
    end
    ACKD_n = 1'b1;

    // Reset asserted in the middle of a store bus cycle.
    tick();
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_size  = 2'b00;
    bus_if.req_addr  = 32'h0800_0020;
    bus_if.req_wdata = 32'h5555_AAAA;
    tick();
    bus_if.req_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("mid_mreq", 32'(MREQ), 32'd1);
    check("mid_write", 32'(WRITE), 32'd1);
    check("mid_ddt", DDT, 32'h5555_AAAA);
    #2 rst = 1'b0;
    #1;
    check("arst_mreq", 32'(MREQ), 32'd0);
    check("arst_write", 32'(WRITE), 32'd0);
    check("arst_dad", DAD, 32'd0);
    check("arst_size", 32'(SIZE), 32'd0);
    check("arst_rv", 32'(bus_if.resp_valid), 32'd0);
    check("arst_err", 32'(bus_if.resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_rel_ready", 32'(bus_if.req_ready), 32'd1);
    check("arst_rel_mreq", 32'(MREQ), 32'd0);

    do_access("post_rst", 0, 2'b01, 0, 32'h0800_0022, 32'h0, 1, 32'h9999_ABCD, 2'b00, 32'h0000_ABCD, 32'h0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("resp_count", 32'(n_resp), 32'(n_exp_resp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
